// File: rtl/dmem_loader_pkg.sv
// Shared definitions for the host-to-dmem loader: protocol states and frame constants.
package dmem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AH,
    ST_AL,
    ST_CH,
    ST_CL,
    ST_DATA
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [1:0] IDX_LAST     = 2'd3;

endpackage

// File: rtl/dmem_loader.sv
// Parses SYNC/ADDR/CNT/data frames from the UART and writes big-endian words into dmem,
// owning the dmem port while busy and passing the CPU port through otherwise.
module dmem_loader
  import dmem_loader_pkg::*;
#(
  parameter int         DATA_W = 32,
  parameter int         ADDR_W = 16,
  parameter logic [7:0] SYNC   = SYNC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_err,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [DATA_W-1:0] cpu_wd,
  input  logic              cpu_we,
  output logic [ADDR_W-1:0] a,
  output logic [DATA_W-1:0] wd,
  output logic              we,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t state, state_nxt;

  logic [15:0]       addr_q;
  logic [15:0]       cnt_q;
  logic [DATA_W-9:0] asm_q;
  logic [DATA_W-1:0] asm_nxt;
  logic [1:0]        idx_q;
  logic [ADDR_W-1:0] wr_a;
  logic [DATA_W-1:0] wr_d;
  logic              wr_we;
  logic              last_pend;

  logic byte_ok, abort, sync_take, cnt_zero, word_last, frame_last;
  logic done_nxt, err_nxt, busy_nxt;

  // rx_err has priority over a byte presented in the same cycle
  assign byte_ok    = rx_valid & ~rx_err;
  assign abort      = rx_err & (state != ST_IDLE);
  assign sync_take  = (state == ST_IDLE) & byte_ok & (rx_data == SYNC);
  assign cnt_zero   = ({cnt_q[15:8], rx_data} == 16'd0);
  assign word_last  = (state == ST_DATA) & byte_ok & (idx_q == IDX_LAST);
  assign frame_last = word_last & (cnt_q == 16'd1);
  assign asm_nxt    = {asm_q, rx_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (byte_ok) begin
      case (state)
        ST_IDLE: if (rx_data == SYNC) state_nxt = ST_AH;
        ST_AH:   state_nxt = ST_AL;
        ST_AL:   state_nxt = ST_CH;
        ST_CH:   state_nxt = ST_CL;
        ST_CL:   state_nxt = cnt_zero ? ST_IDLE : ST_DATA;
        ST_DATA: if (frame_last) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
    if (abort) state_nxt = ST_IDLE;
  end

  // done for a non-empty frame waits one cycle so busy covers the final write
  always_comb begin
    done_nxt = last_pend | ((state == ST_CL) & byte_ok & cnt_zero);
    err_nxt  = abort;
    busy_nxt = busy;
    if (sync_take)               busy_nxt = 1'b1;
    else if (done_nxt | err_nxt) busy_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      cnt_q     <= '0;
      asm_q     <= '0;
      idx_q     <= '0;
      wr_a      <= '0;
      wr_d      <= '0;
      wr_we     <= 1'b0;
      last_pend <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      wr_we     <= word_last;
      last_pend <= frame_last;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      if (byte_ok) begin
        case (state)
          ST_AH: addr_q[15:8] <= rx_data;
          ST_AL: addr_q[7:0]  <= rx_data;
          ST_CH: cnt_q[15:8]  <= rx_data;
          ST_CL: begin
            cnt_q[7:0] <= rx_data;
            idx_q      <= '0;
          end
          ST_DATA: begin
            asm_q <= asm_nxt[DATA_W-9:0];
            idx_q <= idx_q + 2'd1;
            if (idx_q == IDX_LAST) begin
              wr_d   <= asm_nxt;
              wr_a   <= ADDR_W'(addr_q);
              addr_q <= addr_q + 16'd1;
              cnt_q  <= cnt_q - 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign a  = busy ? wr_a  : cpu_a;
  assign wd = busy ? wr_d  : cpu_wd;
  assign we = busy ? wr_we : cpu_we;

endmodule
